// File: rtl/alu_arbiter.sv
// Two-port arbiter in front of a single registered ALU: grants one request per cycle,
// decodes ALUOp/funct into ALU control and routes each result back via a tag pipeline.
module alu_arbiter #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [1:0]        req0_aluop,
  input  logic [5:0]        req0_funct,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [1:0]        req1_aluop,
  input  logic [5:0]        req1_funct,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic [3:0]        alu_control,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_data,
  output logic              rsp0_zero,
  output logic              rsp0_illegal,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_data,
  output logic              rsp1_zero,
  output logic              rsp1_illegal
);

  localparam logic [3:0] CTRL_AND = 4'b0000;
  localparam logic [3:0] CTRL_OR  = 4'b0001;
  localparam logic [3:0] CTRL_ADD = 4'b0010;
  localparam logic [3:0] CTRL_SUB = 4'b0110;
  localparam logic [3:0] CTRL_SLT = 4'b0111;

  typedef struct packed {
    logic valid;
    logic port;
    logic illegal;
  } tag_t;

  logic              ptr;
  tag_t              stage1;
  tag_t              stage2;
  logic              grant0;
  logic              grant1;
  logic              grant;
  logic              sel;
  logic [1:0]        sel_aluop;
  logic [5:0]        sel_funct;
  logic [DATA_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_b;
  logic [3:0]        dec_control;
  logic              dec_illegal;
  logic              dec_swap;

  // Grant selection: lone requester wins, otherwise pointer or fixed priority.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst && !hold) begin
      if (req0_valid && req1_valid) begin
        if (FIXED_PRIO != 0 || !ptr) grant0 = 1'b1;
        else                         grant1 = 1'b1;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign grant      = grant0 | grant1;
  assign sel        = grant1;
  assign sel_aluop  = sel ? req1_aluop : req0_aluop;
  assign sel_funct  = sel ? req1_funct : req0_funct;
  assign sel_a      = sel ? req1_a : req0_a;
  assign sel_b      = sel ? req1_b : req0_b;

  // ALUOp/funct decode; slt swaps operands because the ALU compares input2 < input1.
  always_comb begin
    dec_control = CTRL_ADD;
    dec_illegal = 1'b0;
    dec_swap    = 1'b0;
    case (sel_aluop)
      2'b00: dec_control = CTRL_ADD;
      2'b01: dec_control = CTRL_SUB;
      2'b10: begin
        case (sel_funct)
          6'b100000: dec_control = CTRL_ADD;
          6'b100010: dec_control = CTRL_SUB;
          6'b100100: dec_control = CTRL_AND;
          6'b100101: dec_control = CTRL_OR;
          6'b101010: begin
            dec_control = CTRL_SLT;
            dec_swap    = 1'b1;
          end
          default:   dec_illegal = 1'b1;
        endcase
      end
      default: dec_illegal = 1'b1;
    endcase
    if (dec_illegal) dec_control = CTRL_ADD;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr          <= 1'b0;
      stage1       <= '0;
      stage2       <= '0;
      alu_control  <= '0;
      alu_a        <= '0;
      alu_b        <= '0;
      rsp0_valid   <= 1'b0;
      rsp0_data    <= '0;
      rsp0_zero    <= 1'b0;
      rsp0_illegal <= 1'b0;
      rsp1_valid   <= 1'b0;
      rsp1_data    <= '0;
      rsp1_zero    <= 1'b0;
      rsp1_illegal <= 1'b0;
    end else begin
      if (grant) begin
        ptr         <= ~sel;
        alu_control <= dec_control;
        if (dec_illegal) begin
          alu_a <= '0;
          alu_b <= '0;
        end else if (dec_swap) begin
          alu_a <= sel_b;
          alu_b <= sel_a;
        end else begin
          alu_a <= sel_a;
          alu_b <= sel_b;
        end
      end

      // Tag pipeline tracks the op in the ALU (stage1) and the op on alu_result (stage2).
      stage1.valid   <= grant;
      stage1.port    <= sel;
      stage1.illegal <= grant & dec_illegal;
      stage2         <= stage1;

      rsp0_valid <= stage2.valid & ~stage2.port;
      rsp1_valid <= stage2.valid & stage2.port;
      if (stage2.valid && !stage2.port) begin
        rsp0_data    <= stage2.illegal ? '0 : alu_result;
        rsp0_zero    <= alu_zero & ~stage2.illegal;
        rsp0_illegal <= stage2.illegal;
      end
      if (stage2.valid && stage2.port) begin
        rsp1_data    <= stage2.illegal ? '0 : alu_result;
        rsp1_zero    <= alu_zero & ~stage2.illegal;
        rsp1_illegal <= stage2.illegal;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: round-robin and fixed-priority instances share
// stimulus, each with its own registered ALU model.
module tb_alu_arbiter;

  localparam logic [1:0] OP_MEM = 2'b00;
  localparam logic [1:0] OP_BEQ = 2'b01;
  localparam logic [1:0] OP_R   = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;
  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_SLT  = 6'b101010;

  logic        clk;
  logic        rst;
  logic        hold;
  logic        req0_valid, req1_valid;
  logic [1:0]  req0_aluop, req1_aluop;
  logic [5:0]  req0_funct, req1_funct;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;

  logic        req0_ready, req1_ready;
  logic [3:0]  alu_control;
  logic [31:0] alu_a, alu_b, alu_result;
  logic        alu_zero;
  logic        rsp0_valid, rsp0_zero, rsp0_illegal;
  logic        rsp1_valid, rsp1_zero, rsp1_illegal;
  logic [31:0] rsp0_data, rsp1_data;

  logic        f_ready0, f_ready1;
  logic [3:0]  f_alu_control;
  logic [31:0] f_alu_a, f_alu_b, f_alu_result;
  logic        f_alu_zero;
  logic        f_rsp0_valid, f_rsp0_zero, f_rsp0_illegal;
  logic        f_rsp1_valid, f_rsp1_zero, f_rsp1_illegal;
  logic [31:0] f_rsp0_data, f_rsp1_data;

  int vectors     = 0;
  int miscompares = 0;

  logic [5:0]  lg_fn  [4] = '{F_SLT, F_SLT, F_AND, F_OR};
  logic [31:0] lg_a   [4] = '{32'd3, 32'd8, 32'h0000F0F0, 32'h0000F0F0};
  logic [31:0] lg_b   [4] = '{32'd8, 32'd3, 32'h00000FF0, 32'h00000FF0};
  logic [31:0] lg_exp [4] = '{32'd1, 32'd0, 32'h000000F0, 32'h0000FFF0};

  alu_arbiter #(.DATA_W(32), .FIXED_PRIO(0)) dut (
    .clk(clk), .rst(rst), .hold(hold),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_aluop(req0_aluop),
    .req0_funct(req0_funct), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_aluop(req1_aluop),
    .req1_funct(req1_funct), .req1_a(req1_a), .req1_b(req1_b),
    .alu_control(alu_control), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_zero(rsp0_zero),
    .rsp0_illegal(rsp0_illegal),
    .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_zero(rsp1_zero),
    .rsp1_illegal(rsp1_illegal)
  );

  alu_arbiter #(.DATA_W(32), .FIXED_PRIO(1)) dut_fixed (
    .clk(clk), .rst(rst), .hold(hold),
    .req0_valid(req0_valid), .req0_ready(f_ready0), .req0_aluop(req0_aluop),
    .req0_funct(req0_funct), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(f_ready1), .req1_aluop(req1_aluop),
    .req1_funct(req1_funct), .req1_a(req1_a), .req1_b(req1_b),
    .alu_control(f_alu_control), .alu_a(f_alu_a), .alu_b(f_alu_b),
    .alu_result(f_alu_result), .alu_zero(f_alu_zero),
    .rsp0_valid(f_rsp0_valid), .rsp0_data(f_rsp0_data), .rsp0_zero(f_rsp0_zero),
    .rsp0_illegal(f_rsp0_illegal),
    .rsp1_valid(f_rsp1_valid), .rsp1_data(f_rsp1_data), .rsp1_zero(f_rsp1_zero),
    .rsp1_illegal(f_rsp1_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered ALU model: slt sets when data_input2 < data_input1, unsigned.
  function automatic logic [31:0] alu_calc(input logic [3:0] c, input logic [31:0] x,
                                           input logic [31:0] y);
    case (c)
      4'b0010: return x + y;
      4'b0110: return x - y;
      4'b0000: return x & y;
      4'b0001: return x | y;
      4'b0111: return (y < x) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    alu_result   <= alu_calc(alu_control, alu_a, alu_b);
    alu_zero     <= (alu_calc(alu_control, alu_a, alu_b) == 32'd0);
    f_alu_result <= alu_calc(f_alu_control, f_alu_a, f_alu_b);
    f_alu_zero   <= (alu_calc(f_alu_control, f_alu_a, f_alu_b) == 32'd0);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input int port, input logic [1:0] op, input logic [5:0] fn,
                       input logic [31:0] a, input logic [31:0] b);
    if (port == 0) begin
      req0_valid = 1'b1; req0_aluop = op; req0_funct = fn; req0_a = a; req0_b = b;
    end else begin
      req1_valid = 1'b1; req1_aluop = op; req1_funct = fn; req1_a = a; req1_b = b;
    end
  endtask

  task automatic idle();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; hold = 1'b0;
    req0_aluop = OP_MEM; req0_funct = '0; req0_a = '0; req0_b = '0;
    req1_aluop = OP_MEM; req1_funct = '0; req1_a = '0; req1_b = '0;
    idle();

    // Reset with both ports requesting
    drive(0, OP_R, F_ADD, 32'd1, 32'd1);
    drive(1, OP_R, F_ADD, 32'd2, 32'd2);
    #1;
    check("rst_ready0", 32'(req0_ready), 32'd0);
    check("rst_ready1", 32'(req1_ready), 32'd0);
    tick(2);
    check("rst_ctrl", 32'(alu_control), 32'd0);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_alu_b", alu_b, 32'd0);
    check("rst_rsp0_data", rsp0_data, 32'd0);
    check("rst_rsp1_data", rsp1_data, 32'd0);
    check("rst_rsp_flags", 32'({rsp0_valid, rsp0_zero, rsp0_illegal,
                                rsp1_valid, rsp1_zero, rsp1_illegal}), 32'd0);
    rst = 1'b0;
    idle();
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("post_rst_rsp_v", 32'({rsp0_valid, rsp1_valid}), 32'd0);
    end

    // Single add on port 0: 5 + 7
    drive(0, OP_R, F_ADD, 32'd5, 32'd7);
    #1;
    check("add_ready0", 32'(req0_ready), 32'd1);
    tick(1);
    idle();
    check("add_ctrl", 32'(alu_control), 32'h2);
    check("add_alu_a", alu_a, 32'd5);
    check("add_alu_b", alu_b, 32'd7);
    check("add_rsp_e0", 32'({rsp0_valid, rsp1_valid}), 32'd0);
    tick(1);
    check("add_rsp_e1", 32'({rsp0_valid, rsp1_valid}), 32'd0);
    tick(1);
    check("add_rsp0_v", 32'(rsp0_valid), 32'd1);
    check("add_rsp0_data", rsp0_data, 32'd12);
    check("add_rsp0_zero", 32'(rsp0_zero), 32'd0);
    check("add_rsp1_v", 32'(rsp1_valid), 32'd0);
    tick(1);
    check("add_rsp_e3", 32'({rsp0_valid, rsp1_valid}), 32'd0);

    // Back-to-back beq on port 1
    drive(1, OP_BEQ, 6'd0, 32'd9, 32'd9);
    #1;
    check("beq_ready1", 32'(req1_ready), 32'd1);
    tick(1);
    drive(1, OP_BEQ, 6'd0, 32'd9, 32'd4);
    tick(1);
    idle();
    tick(1);
    check("beq1_rsp1_v", 32'(rsp1_valid), 32'd1);
    check("beq1_data", rsp1_data, 32'd0);
    check("beq1_zero", 32'(rsp1_zero), 32'd1);
    check("beq1_rsp0_v", 32'(rsp0_valid), 32'd0);
    tick(1);
    check("beq2_rsp1_v", 32'(rsp1_valid), 32'd1);
    check("beq2_data", rsp1_data, 32'd5);
    check("beq2_zero", 32'(rsp1_zero), 32'd0);
    check("beq2_rsp0_hold", rsp0_data, 32'd12);
    tick(1);

    // Contention for 4 cycles: port 0 adds to 2, port 1 adds to 20
    for (int j = 0; j < 7; j++) begin
      if (j >= 3) begin
        check("rr_rsp0_v", 32'(rsp0_valid), 32'(((j - 3) % 2) == 0));
        check("rr_rsp1_v", 32'(rsp1_valid), 32'(((j - 3) % 2) == 1));
        if (((j - 3) % 2) == 0) check("rr_rsp0_data", rsp0_data, 32'd2);
        else                    check("rr_rsp1_data", rsp1_data, 32'd20);
        check("fx_rsp0_v", 32'(f_rsp0_valid), 32'd1);
        check("fx_rsp1_v", 32'(f_rsp1_valid), 32'd0);
      end
      if (j < 4) begin
        drive(0, OP_R, F_ADD, 32'd1, 32'd1);
        drive(1, OP_R, F_ADD, 32'd10, 32'd10);
        #1;
        check("rr_ready0", 32'(req0_ready), 32'((j % 2) == 0));
        check("rr_ready1", 32'(req1_ready), 32'((j % 2) == 1));
        check("fx_ready", 32'({f_ready0, f_ready1}), 32'b10);
      end else begin
        idle();
      end
      tick(1);
    end

    // slt and logic ops back-to-back on port 0
    for (int j = 0; j < 7; j++) begin
      if (j == 1) begin
        check("slt_ctrl", 32'(alu_control), 32'h7);
        check("slt_alu_a", alu_a, 32'd8);
        check("slt_alu_b", alu_b, 32'd3);
      end
      if (j >= 3) begin
        check("lg_rsp0_v", 32'(rsp0_valid), 32'd1);
        check("lg_data", rsp0_data, lg_exp[j-3]);
        check("lg_illegal", 32'(rsp0_illegal), 32'd0);
      end
      if (j < 4) drive(0, OP_R, lg_fn[j], lg_a[j], lg_b[j]);
      else       idle();
      tick(1);
    end

    // hold blocks grants and leaves ALU operands untouched
    hold = 1'b1;
    drive(0, OP_R, F_ADD, 32'd1, 32'd2);
    #1;
    check("hold_ready0", 32'(req0_ready), 32'd0);
    tick(1);
    check("hold_ctrl", 32'(alu_control), 32'h1);
    check("hold_alu_a", alu_a, 32'h0000F0F0);
    tick(2);
    check("hold_rsp0_v", 32'(rsp0_valid), 32'd0);
    hold = 1'b0;
    idle();

    // Illegal funct on port 1, then reserved ALUOp on port 0
    drive(1, OP_R, 6'b000000, 32'd5, 32'd6);
    #1;
    check("ill_ready1", 32'(req1_ready), 32'd1);
    tick(1);
    drive(0, OP_RSV, F_ADD, 32'd7, 32'd7);
    check("ill_ctrl", 32'(alu_control), 32'h2);
    check("ill_alu_a", alu_a, 32'd0);
    check("ill_alu_b", alu_b, 32'd0);
    tick(1);
    idle();
    tick(1);
    check("ill1_rsp1_v", 32'(rsp1_valid), 32'd1);
    check("ill1_illegal", 32'(rsp1_illegal), 32'd1);
    check("ill1_data", rsp1_data, 32'd0);
    check("ill1_zero", 32'(rsp1_zero), 32'd0);
    tick(1);
    check("ill2_rsp0_v", 32'(rsp0_valid), 32'd1);
    check("ill2_illegal", 32'(rsp0_illegal), 32'd1);
    check("ill2_data", rsp0_data, 32'd0);
    check("ill2_rsp1_v", 32'(rsp1_valid), 32'd0);
    tick(1);

    // Reset one edge after an accept discards the op and clears the pointer
    drive(0, OP_R, F_ADD, 32'd2, 32'd3);
    tick(1);
    idle();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("mf_rsp_v", 32'({rsp0_valid, rsp1_valid}), 32'd0);
      tick(1);
    end
    drive(0, OP_R, F_ADD, 32'd1, 32'd1);
    drive(1, OP_R, F_ADD, 32'd1, 32'd1);
    #1;
    check("mf_ptr_ready", 32'({req0_ready, req1_ready}), 32'b10);
    tick(1);
    idle();
    tick(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single registered 32-bit ALU between two requesters, the execute stage (port 0) and the branch/address unit (port 1). Each cycle it grants at most one request, decodes the requester's ALUOp/funct into the ALU's 4-bit control code and drives the ALU operands. It tracks every in-flight operation through a two-stage tag pipeline, so each result and zero flag is routed back to the requester that issued it.

## Interface
- DATA_W, 32: operand and result width.
- FIXED_PRIO, 0: 0 selects round-robin arbitration; 1 means port 0 always wins.

- clk  in  1  clock; everything is updated on the rising edge.
- rst  in  1  synchronous, active-high reset.
- hold  in  1  when high, no request is granted this cycle.
- reqN_valid  in  1  request present (N = 0, 1).
- reqN_ready  out  1  combinational grant; a request is accepted when valid and ready are both high at an edge.
- reqN_aluop  in  2  ALUOp: 00 lw/sw, 01 beq, 10 R-type, 11 reserved.
- reqN_funct  in  6  R-type funct field.
- reqN_a, reqN_b  in  DATA_W  operands (rs, rt).
- alu_control  out  4  to ALU control; registered.
- alu_a, alu_b  out  DATA_W  to ALU data_input1/data_input2; registered.
- alu_result  in  DATA_W  ALU data_output.
- alu_zero  in  1  ALU zero.
- rspN_valid  out  1  one-cycle response strobe.
- rspN_data  out  DATA_W  result.
- rspN_zero  out  1  zero flag.
- rspN_illegal  out  1  the operation did not decode.

## Operation
- Arbitration:
  - If only one port is valid, that port is granted.
  - If both are valid and FIXED_PRIO=0, the port selected by the 1-bit pointer wins. After any grant, the pointer moves to the other port.
  - If both are valid and FIXED_PRIO=1, port 0 wins.
  - hold=1 or rst=1 forces both reqN_ready to 0.
  - reqN_valid must not depend on reqN_ready.
- Decode:
  - aluop 00 -> 0010 (add).
  - aluop 01 -> 0110 (sub).
  - aluop 10 with funct 100000 -> 0010 (add), 100010 -> 0110 (sub), 100100 -> 0000 (and), 100101 -> 0001 (or), 101010 -> 0111 (slt).
  - Any other funct, or aluop 11 -> illegal.
- Operands:
  - The ALU's slt sets its result when data_input2 < data_input1 (unsigned).
  - For slt, the block therefore drives alu_a=reqN_b and alu_b=reqN_a, so the result is (a < b) unsigned.
  - All other operations pass operands unswapped.
- Illegal operations:
  - They are accepted and still occupy an issue slot.
  - alu_control is driven as 0010 with operands 0.
  - The response carries illegal=1, data=0 and zero=0.
- Tag pipeline:
  - Stage 1 holds {valid, port, illegal} for the operation in the ALU this cycle.
  - Stage 2 holds the same fields for the operation whose result is on alu_result.
  - A bubble enters the pipeline whenever no grant occurs.
- Response:
  - From stage 2, the owning port's rsp_valid pulses for one cycle.
  - rsp_data and rsp_zero are registered copies of alu_result and alu_zero.
  - The non-owning port's rsp_valid stays 0, and its data and zero hold their previous values.
- Idle behaviour: when nothing is granted, alu_control, alu_a and alu_b hold their last values. The ALU output in that case is ignored.
- Throughput is one operation per cycle with no stall. Requesters must accept responses unconditionally (there is no response backpressure).

## Timing
- Reset (rst high at an edge):
  - All outputs become 0: alu_control=0000, alu_a=0, alu_b=0, rspN_valid=0, rspN_data=0, rspN_zero=0, rspN_illegal=0.
  - The pointer is set to 0 and both tag stages are cleared.
  - Operations in flight are discarded and produce no response.
  - The first request can be granted in the first cycle after rst is released.
- Accept at edge E: alu_* are registered at E.
- Edge E+1: the ALU registers the result and zero flag.
- Edge E+2: the block registers the response, and rspN_valid is high for the cycle between E+2 and E+3.
  - Fixed latency is 2 edges from acceptance to response.
- Back-to-back grants at E, E+1, E+2 produce responses at E+2, E+3, E+4, in order.
- Simultaneous events:
  - A new grant and a response delivery at the same edge are independent.
  - A response to port 0 and a response to port 1 can never occur in the same cycle.
- hold high for k cycles inserts k bubbles. Responses already in flight still complete.

## Test plan
- Reset: assert rst for 2 cycles with both ports valid -> both ready=0, all outputs 0, no rsp_valid for 3 cycles after release.
- Single add: port 0 sends aluop=10, funct=100000, a=5, b=7 -> alu_control=0010; rsp0_valid exactly 2 edges after accept with data=12, zero=0; rsp1_valid never asserted.
- beq on port 1:
  - aluop=01, a=9, b=9 -> rsp1 data=0, zero=1.
  - Next cycle a=9, b=4 -> data=5, zero=0, delivered back-to-back.
- Contention: both ports valid for 4 cycles -> with FIXED_PRIO=0, grants alternate 0,1,0,1 and responses alternate identically; with FIXED_PRIO=1, all 4 grants go to port 0.
- slt and logic:
  - a=3, b=8 -> alu_a=8, alu_b=3, result 1.
  - a=8, b=3 -> result 0.
  - and of 0xF0F0, 0x0FF0 -> 0x00F0.
  - or of the same operands -> 0xFFF0.
- Illegal op and mid-flight reset:
  - funct=000000 -> rsp illegal=1, data=0.
  - rst asserted one edge after an accept -> no response for that operation, and the pointer resets to 0.
